// File: rtl/gh_uart_pkg.sv
// Shared UART types and helpers: parity FSM states and the parity-bit rule
// used by both the serial parity unit and the TX/RX checkers.
package gh_uart_pkg;

   typedef enum logic [1:0] {P_IDLE, P_DATA, P_PARITY} parity_state_t;

   localparam int DEFAULT_MAX_BITS = 8;

   // Even parity means the parity bit equals the XOR of the data bits.
   function automatic logic parity_bit(input logic acc, input logic eps,
                                       input logic stick, input logic pen);
      if (!pen)
         return 1'b0;
      else if (stick)
         return ~eps;
      else if (eps)
         return acc;
      else
         return ~acc;
   endfunction

endpackage

// File: rtl/gh_parity_unit_serial.sv
// Bit-serial parity generator/checker shared by the UART TX serialiser and
// RX deserialiser; accumulates one word of programmable length.
module gh_parity_unit_serial
   import gh_uart_pkg::*;
#(
   parameter int MAX_BITS = DEFAULT_MAX_BITS,
   parameter int CNT_W    = $clog2(MAX_BITS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             srst,
   input  logic             start,
   input  logic [CNT_W-1:0] word_len,
   input  logic             pen,
   input  logic             eps,
   input  logic             stick,
   input  logic             sd,
   input  logic             d,
   input  logic             chk,
   input  logic             pbit,
   output logic             q,
   output logic             q_valid,
   output logic             busy,
   output logic             done,
   output logic             par_err,
   output logic [CNT_W-1:0] bit_cnt
);

   localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_BITS);

   parity_state_t    r_state;
   logic             r_acc;
   logic             r_pen;
   logic             r_eps;
   logic             r_stick;
   logic             r_done;
   logic             r_par_err;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_len;

   logic [CNT_W-1:0] w_len_in;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_q;

   // Out-of-range lengths fall back to a full-width word.
   assign w_len_in   = (word_len == '0 || word_len > MAX_LEN) ? MAX_LEN : word_len;
   assign w_cnt_next = (r_cnt < r_len) ? r_cnt + 1'b1 : r_cnt;
   assign w_q        = parity_bit(r_acc, r_eps, r_stick, r_pen);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= P_IDLE;
         r_acc     <= 1'b0;
         r_cnt     <= '0;
         r_done    <= 1'b0;
         r_par_err <= 1'b0;
         r_pen     <= 1'b0;
         r_eps     <= 1'b0;
         r_stick   <= 1'b0;
         r_len     <= MAX_LEN;
      end else if (srst) begin
         r_state   <= P_IDLE;
         r_acc     <= 1'b0;
         r_cnt     <= '0;
         r_done    <= 1'b0;
         r_par_err <= 1'b0;
         r_pen     <= 1'b0;
         r_eps     <= 1'b0;
         r_stick   <= 1'b0;
         r_len     <= MAX_LEN;
      end else begin
         r_done <= 1'b0;
         // start overrides any sample or check arriving in the same cycle.
         if (start) begin
            r_state <= P_DATA;
            r_acc   <= 1'b0;
            r_cnt   <= '0;
            r_pen   <= pen;
            r_eps   <= eps;
            r_stick <= stick;
            r_len   <= w_len_in;
         end else begin
            case (r_state)
               P_DATA: begin
                  if (sd) begin
                     r_acc <= r_acc ^ d;
                     r_cnt <= w_cnt_next;
                     if (w_cnt_next == r_len) begin
                        if (r_pen) begin
                           r_state <= P_PARITY;
                        end else begin
                           r_state <= P_IDLE;
                           r_done  <= 1'b1;
                        end
                     end
                  end
               end
               P_PARITY: begin
                  if (chk) begin
                     if (pbit != w_q)
                        r_par_err <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= P_IDLE;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign q       = w_q;
   assign q_valid = (r_state == P_PARITY);
   assign busy    = (r_state != P_IDLE);
   assign done    = r_done;
   assign par_err = r_par_err;
   assign bit_cnt = r_cnt;

endmodule

// File: tb/tb_gh_parity_unit_serial.sv
// Self-checking bench for gh_parity_unit_serial: directed scenarios plus
// randomized words checked against a popcount-based parity model.
module tb_gh_parity_unit_serial;

   logic       clk;
   logic       rst_n;
   logic       srst;
   logic       start;
   logic [3:0] word_len;
   logic       pen;
   logic       eps;
   logic       stick;
   logic       sd;
   logic       d;
   logic       chk;
   logic       pbit;
   logic       q;
   logic       q_valid;
   logic       busy;
   logic       done;
   logic       par_err;
   logic [3:0] bit_cnt;

   int nChecks = 0;
   int nFails  = 0;

   gh_parity_unit_serial #(.MAX_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .srst(srst), .start(start),
      .word_len(word_len), .pen(pen), .eps(eps), .stick(stick),
      .sd(sd), .d(d), .chk(chk), .pbit(pbit),
      .q(q), .q_valid(q_valid), .busy(busy), .done(done),
      .par_err(par_err), .bit_cnt(bit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Parity derived from the count of ones in the word, not from a running XOR.
   function automatic logic modelParity(input logic [15:0] bits, input int n,
                                        input logic p, input logic e, input logic s);
      int ones = 0;
      for (int i = 0; i < n; i++) ones += int'(bits[i]);
      if (!p) return 1'b0;
      if (s) return !e;
      if (e) return (ones % 2) == 1;
      return (ones % 2) == 0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doStart(input int len, input logic p, input logic e, input logic s);
      word_len = len[3:0];
      pen = p; eps = e; stick = s;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic doSd(input logic b);
      sd = 1'b1; d = b;
      tick();
      sd = 1'b0;
   endtask

   task automatic doChk(input logic b);
      chk = 1'b1; pbit = b;
      tick();
      chk = 1'b0;
   endtask

   task automatic test_reset();
      nChecks++;
      if ({q, q_valid, busy, done, par_err, bit_cnt} !== 9'd0) begin
         nFails++;
         $display("[TB] FAIL reset_async: got q/qv/busy/done/err/cnt=%b/%b/%b/%b/%b/%0d want all 0",
                  q, q_valid, busy, done, par_err, bit_cnt);
      end
      #1 rst_n = 1'b1;
      tick();
      nChecks++;
      if ({q, q_valid, busy, done, par_err, bit_cnt} !== 9'd0) begin
         nFails++;
         $display("[TB] FAIL reset_idle: got q/qv/busy/done/err/cnt=%b/%b/%b/%b/%b/%0d want all 0",
                  q, q_valid, busy, done, par_err, bit_cnt);
      end
   endtask

   task automatic test_a5();
      logic [7:0] v = 8'hA5;
      for (int e = 1; e >= 0; e--) begin
         doStart(8, 1'b1, e[0], 1'b0);
         for (int i = 0; i < 8; i++) doSd(v[i]);
         nChecks++;
         if ({q_valid, q, bit_cnt, busy, done} !== {1'b1, ~e[0], 4'd8, 1'b1, 1'b0}) begin
            nFails++;
            $display("[TB] FAIL a5_eps%0d: got qv/q/cnt/busy/done=%b/%b/%0d/%b/%b want 1/%b/8/1/0",
                     e, q_valid, q, bit_cnt, busy, done, ~e[0]);
         end
      end
   endtask

   task automatic test_len5_err();
      logic [4:0] v = 5'b01101;
      doStart(5, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) doSd(v[i]);
      nChecks++;
      if ({q_valid, q, bit_cnt} !== {1'b1, 1'b1, 4'd5}) begin
         nFails++;
         $display("[TB] FAIL len5_q: got qv/q/cnt=%b/%b/%0d want 1/1/5", q_valid, q, bit_cnt);
      end
      doChk(1'b0);
      nChecks++;
      if ({done, par_err, busy} !== 3'b110) begin
         nFails++;
         $display("[TB] FAIL len5_bad_chk: got done/err/busy=%b/%b/%b want 1/1/0", done, par_err, busy);
      end
      tick();
      nChecks++;
      if ({done, par_err} !== 2'b01) begin
         nFails++;
         $display("[TB] FAIL len5_done_pulse: got done/err=%b/%b want 0/1", done, par_err);
      end
      doStart(5, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) doSd(v[i]);
      doChk(1'b1);
      nChecks++;
      if ({done, par_err} !== 2'b11) begin
         nFails++;
         $display("[TB] FAIL len5_sticky: got done/err=%b/%b want 1/1", done, par_err);
      end
   endtask

   task automatic test_srst();
      doStart(5, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) doSd(1'b1);
      srst = 1'b1; sd = 1'b1; start = 1'b1;
      tick();
      srst = 1'b0; sd = 1'b0; start = 1'b0;
      nChecks++;
      if ({busy, q_valid, par_err, q, bit_cnt} !== 8'd0) begin
         nFails++;
         $display("[TB] FAIL srst_parity: got busy/qv/err/q/cnt=%b/%b/%b/%b/%0d want all 0",
                  busy, q_valid, par_err, q, bit_cnt);
      end
   endtask

   task automatic test_stick();
      logic [7:0] v;
      for (int e = 1; e >= 0; e--) begin
         v = 8'($urandom);
         doStart(8, 1'b1, e[0], 1'b1);
         for (int i = 0; i < 8; i++) doSd(v[i]);
         nChecks++;
         if ({q_valid, q} !== {1'b1, ~e[0]}) begin
            nFails++;
            $display("[TB] FAIL stick_eps%0d: got qv/q=%b/%b want 1/%b", e, q_valid, q, ~e[0]);
         end
      end
   endtask

   task automatic test_nopar();
      bit sawValid = 0;
      doStart(7, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         doSd(i[0]);
         sawValid |= q_valid;
      end
      nChecks++;
      if ({busy, done} !== 2'b10) begin
         nFails++;
         $display("[TB] FAIL nopar_mid: got busy/done=%b/%b want 1/0", busy, done);
      end
      doSd(1'b1);
      sawValid |= q_valid;
      nChecks++;
      if ({done, busy, q, sawValid} !== 4'b1000) begin
         nFails++;
         $display("[TB] FAIL nopar_done: got done/busy/q/qv_seen=%b/%b/%b/%b want 1/0/0/0",
                  done, busy, q, sawValid);
      end
      tick();
      nChecks++;
      if (done !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL nopar_pulse: got done=%b want 0", done);
      end
   endtask

   task automatic test_restart();
      doStart(8, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) doSd(1'b1);
      doStart(8, 1'b1, 1'b1, 1'b0);
      nChecks++;
      if ({busy, bit_cnt} !== {1'b1, 4'd0}) begin
         nFails++;
         $display("[TB] FAIL restart_cnt: got busy/cnt=%b/%0d want 1/0", busy, bit_cnt);
      end
      for (int i = 0; i < 8; i++) doSd(i == 0);
      nChecks++;
      if ({q_valid, q} !== 2'b11) begin
         nFails++;
         $display("[TB] FAIL restart_q: got qv/q=%b/%b want 1/1", q_valid, q);
      end
      word_len = 4'd8; pen = 1'b1; eps = 1'b1; stick = 1'b0;
      start = 1'b1; sd = 1'b1; d = 1'b1;
      tick();
      start = 1'b0; sd = 1'b0;
      nChecks++;
      if (bit_cnt !== 4'd0) begin
         nFails++;
         $display("[TB] FAIL start_sd_same: got cnt=%0d want 0", bit_cnt);
      end
      for (int i = 0; i < 8; i++) doSd(1'b0);
      nChecks++;
      if ({q_valid, q} !== 2'b10) begin
         nFails++;
         $display("[TB] FAIL start_sd_acc: got qv/q=%b/%b want 1/0", q_valid, q);
      end
   endtask

   task automatic test_len0();
      doStart(0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) doSd(1'b1);
      nChecks++;
      if ({q_valid, busy, bit_cnt} !== {1'b0, 1'b1, 4'd7}) begin
         nFails++;
         $display("[TB] FAIL len0_7: got qv/busy/cnt=%b/%b/%0d want 0/1/7", q_valid, busy, bit_cnt);
      end
      doSd(1'b1);
      nChecks++;
      if ({q_valid, q, bit_cnt} !== {1'b1, 1'b0, 4'd8}) begin
         nFails++;
         $display("[TB] FAIL len0_8: got qv/q/cnt=%b/%b/%0d want 1/0/8", q_valid, q, bit_cnt);
      end
      doChk(1'b0);
      for (int i = 0; i < 3; i++) doSd(1'b1);
      nChecks++;
      if ({bit_cnt, busy, done, q} !== {4'd8, 1'b0, 1'b0, 1'b0}) begin
         nFails++;
         $display("[TB] FAIL len0_extra_sd: got cnt/busy/done/q=%0d/%b/%b/%b want 8/0/0/0",
                  bit_cnt, busy, done, q);
      end
   endtask

   task automatic test_async_reset();
      doStart(1, 1'b1, 1'b1, 1'b0);
      doSd(1'b1);
      doChk(1'b0);
      doStart(8, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) doSd(1'b1);
      #2 rst_n = 1'b0;
      #1;
      nChecks++;
      if ({q, q_valid, busy, done, par_err, bit_cnt} !== 9'd0) begin
         nFails++;
         $display("[TB] FAIL async_reset: got q/qv/busy/done/err/cnt=%b/%b/%b/%b/%b/%0d want all 0",
                  q, q_valid, busy, done, par_err, bit_cnt);
      end
      #2 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_random();
      logic        modelErr = 1'b0;
      logic [15:0] bits;
      logic        p, e, s, expQ, pb;
      int          len, eff;
      srst = 1'b1;
      tick();
      srst = 1'b0;
      for (int w = 0; w < 30; w++) begin
         len  = $urandom_range(0, 15);
         eff  = (len == 0 || len > 8) ? 8 : len;
         p    = 1'($urandom); e = 1'($urandom); s = 1'($urandom);
         bits = 16'($urandom);
         expQ = modelParity(bits, eff, p, e, s);
         doStart(len, p, e, s);
         for (int i = 0; i < eff; i++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
               chk = 1'($urandom); pbit = 1'($urandom);
               tick();
               chk = 1'b0;
            end
            doSd(bits[i]);
            if (i < eff - 1) begin
               nChecks++;
               if ({busy, bit_cnt} !== {1'b1, 4'(i + 1)}) begin
                  nFails++;
                  $display("[TB] FAIL rnd_cnt w%0d: got busy/cnt=%b/%0d want 1/%0d", w, busy, bit_cnt, i + 1);
               end
            end
         end
         nChecks++;
         if ({q_valid, q, bit_cnt, busy, done} !== {p, expQ, 4'(eff), p, ~p}) begin
            nFails++;
            $display("[TB] FAIL rnd_end w%0d: got qv/q/cnt/busy/done=%b/%b/%0d/%b/%b want %b/%b/%0d/%b/%b",
                     w, q_valid, q, bit_cnt, busy, done, p, expQ, eff, p, ~p);
         end
         if (p) begin
            pb = 1'($urandom);
            modelErr |= (pb != expQ);
            doChk(pb);
            nChecks++;
            if ({done, busy, par_err} !== {1'b1, 1'b0, modelErr}) begin
               nFails++;
               $display("[TB] FAIL rnd_chk w%0d: got done/busy/err=%b/%b/%b want 1/0/%b",
                        w, done, busy, par_err, modelErr);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; srst = 1'b0; start = 1'b0; word_len = 4'd0;
      pen = 1'b0; eps = 1'b0; stick = 1'b0; sd = 1'b0; d = 1'b0;
      chk = 1'b0; pbit = 1'b0;
      #12;
      test_reset();
      test_a5();
      test_len5_err();
      test_srst();
      test_stick();
      test_nopar();
      test_restart();
      test_len0();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/gh_parity_unit_serial.md
Name: gh_parity_unit_serial

Overview:
- Parametrised serial parity generator/checker for the UART core.
- Tracks one data word of programmable length, bit-serially, and accumulates parity.
- Produces the parity bit in odd, even, stick-0 or stick-1 mode, or no parity.
- Optionally compares a received parity bit and flags a parity error. Used by both the TX serialiser (generate) and the RX deserialiser (check).

Parameters:
- MAX_BITS, 8, maximum data bits per word (legal 1..16).
- CNT_W, $clog2(MAX_BITS+1), width of the bit counter and word_len (derived; not overridden).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- srst  in  1  synchronous clear: FSM, counter, accumulator and par_err.
- start  in  1  begin a new word; latches configuration.
- word_len  in  CNT_W  data bits per word, latched at start.
- pen  in  1  parity enable, latched at start.
- eps  in  1  even-parity select (1 = even), latched at start.
- stick  in  1  stick parity, latched at start.
- sd  in  1  sample-data pulse.
- d  in  1  data bit, valid when sd=1.
- chk  in  1  parity-bit sample pulse (RX side).
- pbit  in  1  received parity bit, valid when chk=1.
- q  out  1  generated parity bit.
- q_valid  out  1  q is final (PARITY state).
- busy  out  1  state != IDLE.
- done  out  1  one-cycle word-complete pulse.
- par_err  out  1  sticky parity-error flag.
- bit_cnt  out  CNT_W  data bits sampled so far in the current word.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; acc, bit_cnt, done, par_err all 0.
  - Latched config cleared: pen=0, eps=0, stick=0, len=MAX_BITS.
  - q=0, q_valid=0, busy=0.
- srst=1 has the same effect on the next clk edge and has priority over all other inputs.
- States:
  - IDLE: start -> DATA.
  - DATA: counts sd pulses. On the sd that makes bit_cnt equal len: if pen=1 -> PARITY, else -> IDLE with done=1 on the next cycle.
  - PARITY: q_valid=1. On chk: compare pbit with q, set par_err if they differ, assert done, go to IDLE.
  - PARITY with pen=1 but no chk: stays in PARITY until start or srst. This is the TX usage; TX issues start for the next word.
- start, from any state:
  - clears acc and bit_cnt, latches config, enters DATA. par_err is not cleared by start.
  - word_len of 0 or greater than MAX_BITS is latched as MAX_BITS.
  - start in the same cycle as sd or chk: start wins and the bit is not sampled.
- Accumulator:
  - acc <= acc ^ d on sd in DATA.
  - bit_cnt increments by 1 per sd in DATA and saturates at len.
  - sd outside DATA is ignored. chk outside PARITY is ignored.
- q (combinational from registered state):
  - pen=0: q=0.
  - stick=1: q = ~eps.
  - eps=1: q = acc.
  - eps=0: q = ~acc.
- Latency:
  - q is final in the cycle after the last sd.
  - done is high exactly one cycle, on the cycle after the completing sd (pen=0) or after chk (pen=1).
- par_err stays set until srst or rst_n. A later matching check does not clear it.

Decomposition:
- Package gh_uart_pkg holds:
  - typedef enum logic [1:0] {P_IDLE, P_DATA, P_PARITY} parity_state_t;
  - localparam DEFAULT_MAX_BITS = 8;
  - function parity_bit(acc, eps, stick, pen), shared with the TX/RX checker.
- No sub-module. The counter and accumulator are a few lines each and stay inline.

Test Plan:
- eps=1, pen=1, word_len=8, bits of 0xA5 LSB-first -> q_valid=1 and q=0 on the cycle after the 8th sd. Repeat with eps=0 -> q=1.
- word_len=5, bits 1,0,1,1,0, eps=1, pen=1 -> q=1 and bit_cnt=5; chk with pbit=0 -> par_err=1 and done pulses 1 cycle; a later word with a good pbit leaves par_err=1.
- stick=1, eps=1, pen=1, any 8 bits -> q=0; stick=1, eps=0 -> q=1. pen=0, 7 bits -> done one cycle after the 7th sd, q_valid never asserts.
- start after 3 of 8 bits, then 8 bits of 0x01 -> bit_cnt restarts at 0 and q=1 (even); start and sd in the same cycle -> bit not counted.
- word_len=0 -> 8 bits required before done/PARITY; extra sd pulses after the word are ignored and bit_cnt stays 8.
- rst_n low for a fraction of a cycle mid-word -> all outputs 0 immediately (asynchronous). srst in PARITY with par_err=1 -> IDLE and par_err=0 on the next edge.
